// File: rtl/pipelined_datapath.sv
// Two-stage (EX -> OUT) register-file datapath with a valid/ready handshake
// on both the instruction side and the result side. Operands are read when
// an instruction is accepted, with a bypass from the instruction currently
// in EX so dependent instructions can issue back-to-back without bubbles.
module pipelined_datapath #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 2,
   parameter int IMM_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instValid,
   output logic              instReady,
   input  logic [ADDR_W-1:0] srcReg1Addr,
   input  logic [ADDR_W-1:0] srcReg2Addr,
   input  logic [ADDR_W-1:0] destRegAddr,
   input  logic [2:0]        aluOp,
   input  logic              regWrite,
   input  logic [IMM_W-1:0]  immediate,
   output logic [WIDTH-1:0]  aluResult,
   output logic [3:0]        flags,
   output logic              resultValid,
   input  logic              resultReady,
   input  logic [ADDR_W-1:0] dbgAddr,
   output logic [WIDTH-1:0]  dbgData
);

   localparam int NREG = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      OP_ADD   = 3'b000,
      OP_SUB   = 3'b001,
      OP_AND   = 3'b010,
      OP_OR    = 3'b011,
      OP_XOR   = 3'b100,
      OP_SLT   = 3'b101,
      OP_MOV   = 3'b110,
      OP_LOADI = 3'b111
   } alu_op_t;

   // Register file (flops: every entry clears on reset and is read combinationally)
   logic [WIDTH-1:0] rf_reg [NREG];

   // EX stage
   logic              ex_valid_reg;
   alu_op_t           ex_op_reg;
   logic [ADDR_W-1:0] ex_dest_reg;
   logic              ex_we_reg;
   logic [IMM_W-1:0]  ex_imm_reg;
   logic [WIDTH-1:0]  ex_a_reg;
   logic [WIDTH-1:0]  ex_b_reg;

   // OUT stage
   logic [WIDTH-1:0]  result_reg;
   logic [3:0]        flags_reg;
   logic              res_valid_reg;

   // ALU outputs for the EX-stage instruction
   logic [WIDTH-1:0]  alu_res_next;
   logic [3:0]        alu_flags_next;

   // Handshake / pipeline movement
   logic              out_free;
   logic              ex_advance;
   logic              accept;
   logic              rf_we;
   logic [WIDTH-1:0]  op_a_next;
   logic [WIDTH-1:0]  op_b_next;

   // OUT can take a new result when it is empty or its result is consumed now
   assign out_free   = !res_valid_reg || resultReady;
   assign ex_advance = ex_valid_reg && out_free;
   assign instReady  = !ex_valid_reg || out_free;
   assign accept     = instValid && instReady;
   assign rf_we      = ex_advance && ex_we_reg;

   // Operand read with bypass: an accept while EX is occupied implies EX is
   // advancing this edge, so its result is the freshest value of its dest.
   assign op_a_next = (ex_valid_reg && ex_we_reg && (ex_dest_reg == srcReg1Addr))
                      ? alu_res_next : rf_reg[srcReg1Addr];
   assign op_b_next = (ex_valid_reg && ex_we_reg && (ex_dest_reg == srcReg2Addr))
                      ? alu_res_next : rf_reg[srcReg2Addr];

   assign dbgData     = rf_reg[dbgAddr];
   assign aluResult   = result_reg;
   assign flags       = flags_reg;
   assign resultValid = res_valid_reg;

   // ALU: result plus {carry, overflow, negative, zero}
   always_comb begin
      logic [WIDTH:0] sum_ext;
      logic           carry;
      logic           ovf;
      sum_ext      = '0;
      carry        = 1'b0;
      ovf          = 1'b0;
      alu_res_next = '0;
      unique case (ex_op_reg)
         OP_ADD: begin
            sum_ext      = {1'b0, ex_a_reg} + {1'b0, ex_b_reg};
            alu_res_next = sum_ext[WIDTH-1:0];
            carry        = sum_ext[WIDTH];
            ovf          = (ex_a_reg[WIDTH-1] == ex_b_reg[WIDTH-1]) &&
                           (alu_res_next[WIDTH-1] != ex_a_reg[WIDTH-1]);
         end
         OP_SUB: begin
            // a + ~b + 1: the carry out is the inverted borrow
            sum_ext      = {1'b0, ex_a_reg} + {1'b0, ~ex_b_reg} + (WIDTH+1)'(1);
            alu_res_next = sum_ext[WIDTH-1:0];
            carry        = sum_ext[WIDTH];
            ovf          = (ex_a_reg[WIDTH-1] != ex_b_reg[WIDTH-1]) &&
                           (alu_res_next[WIDTH-1] != ex_a_reg[WIDTH-1]);
         end
         OP_AND:   alu_res_next = ex_a_reg & ex_b_reg;
         OP_OR:    alu_res_next = ex_a_reg | ex_b_reg;
         OP_XOR:   alu_res_next = ex_a_reg ^ ex_b_reg;
         OP_SLT:   alu_res_next = ($signed(ex_a_reg) < $signed(ex_b_reg)) ? WIDTH'(1) : '0;
         OP_MOV:   alu_res_next = ex_a_reg;
         OP_LOADI: alu_res_next = WIDTH'($signed(ex_imm_reg));
         default:  alu_res_next = '0;
      endcase
      alu_flags_next = {carry, ovf, alu_res_next[WIDTH-1], (alu_res_next == '0)};
   end

   // EX stage register: capture a new instruction on accept, empty when it leaves
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_reg <= 1'b0;
         ex_op_reg    <= OP_ADD;
         ex_dest_reg  <= '0;
         ex_we_reg    <= 1'b0;
         ex_imm_reg   <= '0;
         ex_a_reg     <= '0;
         ex_b_reg     <= '0;
      end else if (accept) begin
         ex_valid_reg <= 1'b1;
         ex_op_reg    <= alu_op_t'(aluOp);
         ex_dest_reg  <= destRegAddr;
         ex_we_reg    <= regWrite;
         ex_imm_reg   <= immediate;
         ex_a_reg     <= op_a_next;
         ex_b_reg     <= op_b_next;
      end else if (ex_advance) begin
         ex_valid_reg <= 1'b0;
      end
   end

   // OUT stage register: load on EX advance, clear valid when consumed and not refilled
   always_ff @(posedge clk) begin
      if (reset) begin
         result_reg    <= '0;
         flags_reg     <= '0;
         res_valid_reg <= 1'b0;
      end else if (ex_advance) begin
         result_reg    <= alu_res_next;
         flags_reg     <= alu_flags_next;
         res_valid_reg <= 1'b1;
      end else if (res_valid_reg && resultReady) begin
         res_valid_reg <= 1'b0;
      end
   end

   // Register file write port: one flop bank per entry, written as EX moves to OUT
   for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
      always_ff @(posedge clk) begin
         if (reset) begin
            rf_reg[gi] <= '0;
         end else if (rf_we && (ex_dest_reg == ADDR_W'(gi))) begin
            rf_reg[gi] <= alu_res_next;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed bench for pipelined_datapath: runs the same program on an 8-bit
// (4 register) and a 16-bit (8 register) instance, one after the other.
module tb_pipelined_datapath;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, SLT = 3'd5, MOV = 3'd6, LDI = 3'd7;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, inst_valid, reg_write, result_ready, sel16;
   logic [2:0] src1, src2, dest, alu_op, dbg_addr;
   logic [3:0] imm;

   logic        ready8, rv8, ready16, rv16;
   logic [7:0]  res8, dbg8;
   logic [15:0] res16, dbg16;
   logic [3:0]  flags8, flags16;

   pipelined_datapath #(.WIDTH(8), .ADDR_W(2), .IMM_W(4)) dut8 (
      .clk(clk), .reset(reset), .instValid(inst_valid && !sel16), .instReady(ready8),
      .srcReg1Addr(src1[1:0]), .srcReg2Addr(src2[1:0]), .destRegAddr(dest[1:0]),
      .aluOp(alu_op), .regWrite(reg_write), .immediate(imm),
      .aluResult(res8), .flags(flags8), .resultValid(rv8), .resultReady(result_ready),
      .dbgAddr(dbg_addr[1:0]), .dbgData(dbg8));

   pipelined_datapath #(.WIDTH(16), .ADDR_W(3), .IMM_W(4)) dut16 (
      .clk(clk), .reset(reset), .instValid(inst_valid && sel16), .instReady(ready16),
      .srcReg1Addr(src1), .srcReg2Addr(src2), .destRegAddr(dest),
      .aluOp(alu_op), .regWrite(reg_write), .immediate(imm),
      .aluResult(res16), .flags(flags16), .resultValid(rv16), .resultReady(result_ready),
      .dbgAddr(dbg_addr), .dbgData(dbg16));

   logic        obs_ready, obs_rv;
   logic [15:0] obs_res, obs_dbg, mask;
   logic [3:0]  obs_flags;
   assign obs_ready = sel16 ? ready16 : ready8;
   assign obs_rv    = sel16 ? rv16 : rv8;
   assign obs_res   = sel16 ? res16 : {8'h00, res8};
   assign obs_flags = sel16 ? flags16 : flags8;
   assign obs_dbg   = sel16 ? dbg16 : {8'h00, dbg8};
   assign mask      = sel16 ? 16'hFFFF : 16'h00FF;

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   typedef struct {
      string       tag;
      logic [15:0] res;
      logic [3:0]  flg;
   } exp_t;
   exp_t exp_q[$];

   task automatic push_exp(input string tag, input logic [15:0] r, input logic [3:0] f);
      exp_t e;
      e.tag = tag;
      e.res = r & mask;
      e.flg = f;
      exp_q.push_back(e);
   endtask

   // Result monitor: every consumed result is compared in order against the queue
   always @(negedge clk) begin
      #2;
      if (!reset && obs_rv && result_ready) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_result", {15'b0, obs_rv}, 16'h0000);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("W%0d %s: result %h flags %b (expect %h %b)",
                     sel16 ? 16 : 8, e.tag, obs_res, obs_flags, e.res, e.flg);
            check_val({e.tag, "_res"}, obs_res, e.res);
            check_val({e.tag, "_flg"}, {12'b0, obs_flags}, {12'b0, e.flg});
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s1,
                        input logic [2:0] s2, input logic we, input logic [3:0] im);
      int n = 0;
      @(negedge clk);
      alu_op = op; dest = d; src1 = s1; src2 = s2; reg_write = we; imm = im;
      inst_valid = 1'b1;
      #1;
      while (!obs_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 20) check_val("issue_timeout", {15'b0, obs_ready}, 16'h0001);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      inst_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      check_val("drain_left", 16'(exp_q.size()), 16'h0000);
   endtask

   task automatic check_reg(input string tag, input logic [2:0] a, input logic [15:0] v);
      dbg_addr = a;
      #1;
      check_val(tag, obs_dbg, v & mask);
   endtask

   task automatic check_reset_state(input string tag, input int nreg);
      check_val({tag, "_valid"}, {15'b0, obs_rv}, 16'h0000);
      check_val({tag, "_result"}, obs_res, 16'h0000);
      check_val({tag, "_flags"}, {12'b0, obs_flags}, 16'h0000);
      check_val({tag, "_ready"}, {15'b0, obs_ready}, 16'h0001);
      for (int r = 0; r < nreg; r++) check_reg($sformatf("%s_R%0d", tag, r), 3'(r), 16'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; inst_valid = 1'b0; reg_write = 1'b0; result_ready = 1'b1; sel16 = 1'b0;
      src1 = '0; src2 = '0; dest = '0; alu_op = '0; dbg_addr = '0; imm = '0;

      for (int s = 0; s < 2; s++) begin
         logic [15:0] minv, maxv;
         int          nreg, width;
         sel16 = s[0];
         width = s ? 16 : 8;
         nreg  = s ? 8 : 4;
         minv  = s ? 16'h8000 : 16'h0080;
         maxv  = s ? 16'h7FFF : 16'h007F;

         // Reset
         @(negedge clk); reset = 1'b1; inst_valid = 1'b0;
         repeat (2) @(posedge clk);
         @(negedge clk); reset = 1'b0;
         #1;
         check_reset_state("reset", nreg);

         // LOADI -1 into R0
         push_exp("loadi_m1", 16'hFFFF, 4'b0010);
         issue(LDI, 3'd0, 3'd0, 3'd0, 1'b1, 4'hF);
         idle(); drain();
         check_reg("R0_ones", 3'd0, 16'hFFFF);

         // Back-to-back dependent instructions through the bypass
         push_exp("sub_r1", 16'h0000, 4'b1001);
         push_exp("sub_r2", 16'h0001, 4'b0000);
         push_exp("add_r3", 16'h0000, 4'b1001);
         issue(SUB, 3'd1, 3'd0, 3'd0, 1'b1, 4'h0);
         issue(SUB, 3'd2, 3'd1, 3'd0, 1'b1, 4'h0);
         issue(ADD, 3'd3, 3'd0, 3'd2, 1'b1, 4'h0);
         idle(); drain();
         check_reg("R1_b2b", 3'd1, 16'h0000);
         check_reg("R2_b2b", 3'd2, 16'h0001);
         check_reg("R3_b2b", 3'd3, 16'h0000);

         // Build the most negative value by doubling -8, then probe overflow and SLT
         push_exp("loadi_1", 16'h0001, 4'b0000);
         push_exp("loadi_m8", 16'hFFF8, 4'b0010);
         issue(LDI, 3'd1, 3'd0, 3'd0, 1'b1, 4'h1);
         issue(LDI, 3'd2, 3'd0, 3'd0, 1'b1, 4'h8);
         for (int k = 1; k <= width - 4; k++) begin
            push_exp($sformatf("dbl%0d", k), 16'hFFF8 << k, 4'b1010);
            issue(ADD, 3'd2, 3'd2, 3'd2, 1'b1, 4'h0);
         end
         push_exp("sub_max", maxv, 4'b1100);
         push_exp("add_ovf", minv, 4'b0110);
         push_exp("slt", 16'h0001, 4'b0000);
         issue(SUB, 3'd3, 3'd2, 3'd1, 1'b1, 4'h0);
         issue(ADD, 3'd0, 3'd3, 3'd1, 1'b1, 4'h0);
         issue(SLT, 3'd3, 3'd2, 3'd1, 1'b1, 4'h0);
         if (s == 1) begin
            push_exp("mov_r7", minv, 4'b0010);
            issue(MOV, 3'd7, 3'd2, 3'd0, 1'b1, 4'h0);
         end
         idle(); drain();
         check_reg("R0_min", 3'd0, minv);
         check_reg("R1_one", 3'd1, 16'h0001);
         check_reg("R2_min", 3'd2, minv);
         check_reg("R3_slt", 3'd3, 16'h0001);
         if (s == 1) begin
            for (int r = 4; r < 7; r++) check_reg($sformatf("R%0d_untouched", r), 3'(r), 16'h0000);
            check_reg("R7_mov", 3'd7, minv);
         end

         // Stall: two instructions issued with the consumer blocked
         @(negedge clk); result_ready = 1'b0;
         push_exp("stall_x", 16'h0005, 4'b0000);
         push_exp("stall_y", 16'h000A, 4'b0000);
         issue(LDI, 3'd1, 3'd0, 3'd0, 1'b1, 4'h5);
         issue(ADD, 3'd2, 3'd1, 3'd1, 1'b1, 4'h0);
         for (int c = 0; c < 3; c++) begin
            idle();
            #1;
            check_val($sformatf("stall%0d_ready", c), {15'b0, obs_ready}, 16'h0000);
            check_val($sformatf("stall%0d_valid", c), {15'b0, obs_rv}, 16'h0001);
            check_val($sformatf("stall%0d_result", c), obs_res, 16'h0005);
            check_reg($sformatf("stall%0d_R2_deferred", c), 3'd2, minv);
         end
         @(negedge clk); result_ready = 1'b1;
         drain();
         check_reg("R1_after_stall", 3'd1, 16'h0005);
         check_reg("R2_after_stall", 3'd2, 16'h000A);

         // Reset while stalled with EX occupied: nothing in flight may land
         @(negedge clk); result_ready = 1'b0;
         issue(LDI, 3'd0, 3'd0, 3'd0, 1'b1, 4'h7);
         issue(LDI, 3'd3, 3'd0, 3'd0, 1'b1, 4'h6);
         @(negedge clk); inst_valid = 1'b0; reset = 1'b1;
         @(negedge clk); reset = 1'b0;
         #1;
         check_reset_state("midstall_reset", nreg);
         result_ready = 1'b1;
         repeat (3) @(posedge clk);
         @(negedge clk);
         #1;
         check_val("post_reset_valid", {15'b0, obs_rv}, 16'h0000);
         check_reg("post_reset_R3", 3'd3, 16'h0000);
      end

      check_val("queue_left", 16'(exp_q.size()), 16'h0000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
